// File: rtl/dff_ctrl_sequencer.sv
// Control sequencer for a sync-reset/sync-preset register bank.
// Turns async reset/preset requests into clock-aligned pulses of fixed length.
module dff_ctrl_sequencer #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter int RST_CYCLES  = 2,
  parameter int PRE_CYCLES  = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rst_req,
  input  logic             pre_req,
  input  logic [WIDTH-1:0] d_in,
  input  logic             d_valid,
  output logic             d_ready,
  output logic             reset,
  output logic             preset,
  output logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done
);

  localparam int MRP = (RST_CYCLES > PRE_CYCLES) ?
                       RST_CYCLES : PRE_CYCLES;
  localparam int MAXC = (MRP > GAP_CYCLES) ? MRP : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] RST_LD = CW'(RST_CYCLES);
  localparam logic [CW-1:0] PRE_LD = CW'(PRE_CYCLES);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    RST,
    PRE,
    GAP
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rst_pend_q, rst_pend_d;
  logic pre_pend_q, pre_pend_d;
  logic [SYNC_STAGES-1:0] rst_sync_q, pre_sync_q;
  logic rst_prev_q, pre_prev_q;
  logic rst_edge_q, pre_edge_q;
  logic reset_q, preset_q;
  logic [WIDTH-1:0] d_q;

  // Edge pulses are registered, adding one cycle after the synchronizer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= '0;
      pre_sync_q <= '0;
      rst_prev_q <= 1'b0;
      pre_prev_q <= 1'b0;
      rst_edge_q <= 1'b0;
      pre_edge_q <= 1'b0;
    end else begin
      rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], rst_req};
      pre_sync_q <= {pre_sync_q[SYNC_STAGES-2:0], pre_req};
      rst_prev_q <= rst_sync_q[SYNC_STAGES-1];
      pre_prev_q <= pre_sync_q[SYNC_STAGES-1];
      rst_edge_q <= rst_sync_q[SYNC_STAGES-1] & ~rst_prev_q;
      pre_edge_q <= pre_sync_q[SYNC_STAGES-1] & ~pre_prev_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rst_pend_d = rst_pend_q;
    pre_pend_d = pre_pend_q;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rst_edge_q || rst_pend_q) begin
          state_d    = RST;
          cnt_d      = RST_LD;
          rst_pend_d = 1'b0;
          if (pre_edge_q) pre_pend_d = 1'b1;
        end else if (pre_edge_q || pre_pend_q) begin
          state_d    = PRE;
          cnt_d      = PRE_LD;
          pre_pend_d = 1'b0;
        end
      end
      RST: begin
        if (pre_edge_q) pre_pend_d = 1'b1;
        if (cnt_q == ONE) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      PRE: begin
        if (rst_edge_q) begin
          state_d    = RST;
          cnt_d      = RST_LD;
          rst_pend_d = 1'b0;
        end else if (cnt_q == ONE) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      GAP: begin
        if (rst_edge_q) rst_pend_d = 1'b1;
        if (pre_edge_q) pre_pend_d = 1'b1;
        if (cnt_q == ONE) begin
          state_d = IDLE;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign d_ready = (state_q == IDLE) && !rst_pend_q &&
                   !pre_pend_q && !rst_edge_q && !pre_edge_q;

  // reset/preset come straight from flops so the bank sees clean levels
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RST;
      cnt_q      <= RST_LD;
      rst_pend_q <= 1'b0;
      pre_pend_q <= 1'b0;
      reset_q    <= 1'b1;
      preset_q   <= 1'b0;
      d_q        <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_pend_q <= rst_pend_d;
      pre_pend_q <= pre_pend_d;
      reset_q    <= (state_d == RST);
      preset_q   <= (state_d == PRE);
      if (d_valid && d_ready) d_q <= d_in;
    end
  end

  assign reset  = reset_q;
  assign preset = preset_q;
  assign d      = d_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_dff_ctrl_sequencer.sv
// Bench for dff_ctrl_sequencer: sequence model compared every cycle,
// plus hand-computed pulse positions for the directed scenarios.
module tb_dff_ctrl_sequencer;

  localparam int S  = 2;
  localparam int RC = 2;
  localparam int PC = 2;
  localparam int GC = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic rst_req = 1'b0;
  logic pre_req = 1'b0;
  logic [0:0] d_in = 1'b0;
  logic d_valid = 1'b0;
  logic d_ready, reset, preset, busy, done;
  logic [0:0] d;

  dff_ctrl_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .rst_req(rst_req), .pre_req(pre_req),
    .d_in(d_in), .d_valid(d_valid),
    .d_ready(d_ready), .reset(reset),
    .preset(preset), .d(d),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: kind 0=idle 1=reset 2=preset 3=gap, left=cycles remaining
  int m_kind = 1;
  int m_left = RC;
  bit m_rp = 0, m_pp = 0;
  bit hr[0:S+1];
  bit hp[0:S+1];
  logic m_d = 1'b0;
  logic e_reset = 1, e_preset = 0, e_busy = 1;
  logic e_done = 0, e_ready = 0;

  task automatic set_exp();
    bit er, ep;
    er = hr[S] & ~hr[S+1];
    ep = hp[S] & ~hp[S+1];
    e_reset  = (m_kind == 1);
    e_preset = (m_kind == 2);
    e_busy   = (m_kind != 0);
    e_done   = (m_kind == 3) && (m_left == 1);
    e_ready  = (m_kind == 0) && !m_rp && !m_pp && !er && !ep;
  endtask

  task automatic model_init();
    m_kind = 1; m_left = RC;
    m_rp = 0; m_pp = 0; m_d = 1'b0;
    for (int k = 0; k <= S + 1; k++) begin
      hr[k] = 0; hp[k] = 0;
    end
    set_exp();
  endtask

  task automatic model_step();
    bit er, ep;
    er = hr[S] & ~hr[S+1];
    ep = hp[S] & ~hp[S+1];
    if (m_kind == 0 && !m_rp && !m_pp && !er && !ep && d_valid)
      m_d = d_in;
    if (m_kind == 0) begin
      if (er || m_rp) begin
        m_kind = 1; m_left = RC; m_rp = 0;
        if (ep) m_pp = 1;
      end else if (ep || m_pp) begin
        m_kind = 2; m_left = PC; m_pp = 0;
      end
    end else if (m_kind == 1) begin
      if (ep) m_pp = 1;
      if (m_left == 1) begin m_kind = 3; m_left = GC; end
      else m_left--;
    end else if (m_kind == 2) begin
      if (er) begin m_kind = 1; m_left = RC; m_rp = 0; end
      else if (m_left == 1) begin m_kind = 3; m_left = GC; end
      else m_left--;
    end else begin
      if (er) m_rp = 1;
      if (ep) m_pp = 1;
      if (m_left == 1) m_kind = 0;
      else m_left--;
    end
    for (int k = S + 1; k > 0; k--) begin
      hr[k] = hr[k-1]; hp[k] = hp[k-1];
    end
    hr[0] = rst_req; hp[0] = pre_req;
    set_exp();
  endtask

  initial begin
    model_init();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_init();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("reset", reset, e_reset);
      chk("preset", preset, e_preset);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("d_ready", d_ready, e_ready);
      chk("d", d, m_d);
      chk("overlap", reset & preset, 0);
    end
  end

  // Window recorder: index i is the negedge after the i-th posedge
  logic rv[0:31], pv[0:31], dv[0:31];
  int c_r, c_p, c_d, f_r, f_p, c_ov;

  task automatic run_win(int ra, int pa, int hold, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rv[i] = reset; pv[i] = preset; dv[i] = done;
      if (i == ra) rst_req = 1'b1;
      if (i == pa) pre_req = 1'b1;
      if (ra >= 0 && i == ra + hold) rst_req = 1'b0;
      if (pa >= 0 && i == pa + hold) pre_req = 1'b0;
    end
    rst_req = 1'b0; pre_req = 1'b0;
    c_r = 0; c_p = 0; c_d = 0; c_ov = 0;
    f_r = -1; f_p = -1;
    for (int i = 0; i < n; i++) begin
      if (rv[i]) c_r++;
      if (pv[i]) c_p++;
      if (dv[i]) c_d++;
      if (rv[i] && pv[i]) c_ov++;
      if (rv[i] && f_r < 0) f_r = i;
      if (pv[i] && f_p < 0) f_p = i;
    end
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("por_reset", reset, 1);
    chk("por_preset", preset, 0);
    chk("por_busy", busy, 1);
    chk("por_ready", d_ready, 0);
    chk("por_d", d, 0);
    @(posedge clk); #2 reset_n = 1'b1;
    run_win(-1, -1, 0, 6);
    chk("t1_first_rst", f_r, 0);
    chk("t1_rst_len", c_r, 2);
    chk("t1_dones", c_d, 1);
    chk("t1_ready", d_ready, 1);
    chk("t1_d", d, 0);

    d_in = 1'b1; d_valid = 1'b1;
    @(negedge clk);
    chk("t2_load", d, 1);
    d_in = 1'b0; d_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("t2_hold", d, 1);

    run_win(0, -1, 10, 14);
    chk("t3_first_rst", f_r, 4);
    chk("t3_rst_len", c_r, 2);
    chk("t3_dones", c_d, 1);
    chk("t3_d", d, 1);

    run_win(1, 0, 2, 14);
    chk("t4_first_pre", f_p, 4);
    chk("t4_pre_len", c_p, 1);
    chk("t4_first_rst", f_r, 5);
    chk("t4_rst_len", c_r, 2);
    chk("t4_overlap", c_ov, 0);
    chk("t4_dones", c_d, 1);

    run_win(0, 0, 3, 16);
    chk("t5_first_rst", f_r, 4);
    chk("t5_rst_len", c_r, 2);
    chk("t5_first_pre", f_p, 8);
    chk("t5_pre_len", c_p, 2);
    chk("t5_dones", c_d, 2);

    run_win(-1, 0, 2, 5);
    chk("t6_in_pre", preset, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_abort_rst", reset, 1);
    chk("t6_abort_pre", preset, 0);
    chk("t6_abort_d", d, 0);
    @(posedge clk); #2 reset_n = 1'b1;
    run_win(-1, -1, 0, 8);
    chk("t6_first_rst", f_r, 0);
    chk("t6_rst_len", c_r, 2);
    chk("t6_no_pre", c_p, 0);
    chk("t6_dones", c_d, 1);
    chk("t6_ready", d_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
